// File: rtl/csdf_flux_scheduler_if.sv
// Handshake bundle between the CSDF flux scheduler and its FIFOs.
// The master side is the scheduler: it reads the FIFO status flags and
// drives the read/write strobes, the grant tag and the status flags.
interface csdf_flux_scheduler_if #(
  parameter int FLUX      = 2,
  parameter int PORTS     = 2,
  parameter int TAG_WIDTH = $clog2(FLUX)
);
  logic [PORTS*FLUX-1:0] empty;
  logic                  full;
  logic [PORTS*FLUX-1:0] read;
  logic                  write;
  logic [TAG_WIDTH-1:0]  tag;
  logic                  busy;
  logic                  last;

  modport master (
    input  empty, full,
    output read, write, tag, busy, last
  );

  modport slave (
    output empty, full,
    input  read, write, tag, busy, last
  );
endinterface

// File: rtl/csdf_flux_scheduler.sv
// Round-robin, non-interleaved scheduler for a shared CSDF actor datapath.
// A flux is locked for NUM_OP firings plus one output write; the lock is
// atomic, so other fluxes wait even when ready. Strobes are Mealy outputs
// (zero-cycle path from the empty flags to the read strobes) and are
// forced low while reset is asserted.
module csdf_flux_scheduler #(
  parameter int FLUX      = 2,
  parameter int PORTS     = 2,
  parameter int NUM_OP    = 4,
  parameter int TAG_WIDTH = $clog2(FLUX)
) (
  input  logic                    clk,
  input  logic                    rst,
  csdf_flux_scheduler_if.master   bus
);

  localparam int REM_W = $clog2(NUM_OP + 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t                state;
  logic [TAG_WIDTH-1:0]  gnt;
  logic [TAG_WIDTH-1:0]  ptr;
  logic [REM_W-1:0]      rem;

  logic [FLUX-1:0]       rdy;
  logic                  sel_found;
  logic [TAG_WIDTH-1:0]  sel;
  logic [TAG_WIDTH-1:0]  cand;
  logic [TAG_WIDTH-1:0]  cur;
  logic                  fire;
  logic                  last_fire;
  logic                  write_c;
  logic [PORTS*FLUX-1:0] read_c;

  // A flux is ready only when every one of its input FIFOs has data.
  always_comb begin
    rdy = '0;
    for (int j = 0; j < FLUX; j++) begin
      rdy[j] = ~|bus.empty[j*PORTS +: PORTS];
    end
  end

  // Round-robin search starting just after the last granted flux, so the
  // flux that just completed an iteration has the lowest priority.
  always_comb begin
    sel_found = 1'b0;
    sel       = '0;
    cand      = '0;
    for (int o = 1; o <= FLUX; o++) begin
      cand = TAG_WIDTH'((int'(ptr) + o) % FLUX);
      if (!sel_found && rdy[cand]) begin
        sel_found = 1'b1;
        sel       = cand;
      end
    end
  end

  // Decode the firing/write decision for this cycle from state and flags.
  always_comb begin
    cur       = gnt;
    fire      = 1'b0;
    last_fire = 1'b0;
    write_c   = 1'b0;
    case (state)
      IDLE: begin
        cur       = sel_found ? sel : '0;
        fire      = sel_found;
        last_fire = sel_found && (NUM_OP == 1);
      end
      RUN: begin
        fire      = rdy[gnt];
        last_fire = rdy[gnt] && (rem == REM_W'(1));
      end
      HOLD: begin
        write_c   = !bus.full;
      end
      default: begin
        cur = gnt;
      end
    endcase
    // The completing firing writes in the same cycle unless the output is full.
    if (last_fire) begin
      write_c = !bus.full;
    end
    // All ports of the granted flux are strobed together, never a partial set.
    read_c = '0;
    for (int j = 0; j < FLUX; j++) begin
      for (int i = 0; i < PORTS; i++) begin
        read_c[j*PORTS + i] = fire && (cur == TAG_WIDTH'(j));
      end
    end
  end

  assign bus.read  = rst ? read_c    : '0;
  assign bus.write = rst ? write_c   : 1'b0;
  assign bus.tag   = rst ? cur       : '0;
  assign bus.busy  = rst ? (state != IDLE) : 1'b0;
  assign bus.last  = rst ? last_fire : 1'b0;

  // Iteration sequencer: lock on a flux, count firings, then write or hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= '0;
      rem   <= '0;
      ptr   <= TAG_WIDTH'(FLUX - 1);
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            gnt <= sel;
            ptr <= sel;
            rem <= REM_W'(NUM_OP - 1);
            if (NUM_OP == 1) begin
              state <= bus.full ? HOLD : IDLE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (rdy[gnt]) begin
            if (rem == REM_W'(1)) begin
              rem   <= '0;
              state <= bus.full ? HOLD : IDLE;
            end else begin
              rem   <= rem - REM_W'(1);
            end
          end
        end
        HOLD: begin
          if (!bus.full) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Never write into a full output FIFO.
  assert property (@(posedge clk) disable iff (!rst) !(bus.write && bus.full));

  // Never read from an empty input FIFO.
  assert property (@(posedge clk) disable iff (!rst) ((bus.read & bus.empty) == '0));

endmodule

// File: tb/tb_csdf_flux_scheduler.sv
// Self-checking bench for csdf_flux_scheduler: an NUM_OP=4 instance checked
// cycle by cycle against an independent behavioural model through a
// scoreboard queue, plus an NUM_OP=1 instance checked against a table.
module tb_csdf_flux_scheduler;

  localparam int F = 2;
  localparam int P = 2;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  csdf_flux_scheduler_if #(.FLUX(F), .PORTS(P)) bus4 ();
  csdf_flux_scheduler_if #(.FLUX(F), .PORTS(P)) bus1 ();

  csdf_flux_scheduler #(.FLUX(F), .PORTS(P), .NUM_OP(N)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  csdf_flux_scheduler #(.FLUX(F), .PORTS(P), .NUM_OP(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct packed {
    logic [3:0] read;
    logic       write;
    logic       tag;
    logic       busy;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   wtags[$];
  int   checks = 0;
  int   errors = 0;

  // model state: 0=idle, 1=locked/firing, 2=waiting for output space
  int mstate, mgnt, mptr, mcnt;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mstate = 0;
    mgnt   = 0;
    mptr   = F - 1;
    mcnt   = 0;
  endtask

  function automatic logic [3:0] flux_mask(input int k);
    return 4'(((1 << P) - 1) << (k * P));
  endfunction

  function automatic bit flux_ready(input logic [3:0] em, input int k);
    return (em & flux_mask(k)) == 4'b0000;
  endfunction

  // Expected outputs for this cycle and the model's state after the edge.
  task automatic model_eval(input logic [3:0] em, input logic fl, output exp_t e);
    int  k;
    bit  found;
    e = '0;
    case (mstate)
      0: begin
        found = 0;
        k     = 0;
        for (int o = 1; o <= F; o++) begin
          if (!found && flux_ready(em, (mptr + o) % F)) begin
            found = 1;
            k     = (mptr + o) % F;
          end
        end
        if (found) begin
          e.read = flux_mask(k);
          e.tag  = 1'(k);
          mgnt   = k;
          mptr   = k;
          mcnt   = 1;
          mstate = 1;
          if (mcnt == N) begin
            e.last = 1'b1;
            e.write = !fl;
            mstate = fl ? 2 : 0;
          end
        end
      end
      1: begin
        e.busy = 1'b1;
        e.tag  = 1'(mgnt);
        if (flux_ready(em, mgnt)) begin
          e.read = flux_mask(mgnt);
          mcnt++;
          if (mcnt == N) begin
            e.last  = 1'b1;
            e.write = !fl;
            mstate  = fl ? 2 : 0;
          end
        end
      end
      default: begin
        e.busy  = 1'b1;
        e.tag   = 1'(mgnt);
        e.write = !fl;
        mstate  = fl ? 2 : 0;
      end
    endcase
  endtask

  task automatic step(input logic [3:0] em, input logic fl);
    exp_t e;
    exp_t q;
    @(negedge clk);
    bus4.empty = em;
    bus4.full  = fl;
    model_eval(em, fl, e);
    sb.push_back(e);
    #1;
    q = sb.pop_front();
    check("read",  32'(bus4.read),  32'(q.read));
    check("write", 32'(bus4.write), 32'(q.write));
    check("tag",   32'(bus4.tag),   32'(q.tag));
    check("busy",  32'(bus4.busy),  32'(q.busy));
    check("last",  32'(bus4.last),  32'(q.last));
    if (bus4.write) wtags.push_back(int'(bus4.tag));
  endtask

  task automatic check_quiet(input string name);
    check({name, "_read"},  32'(bus4.read),  32'd0);
    check({name, "_write"}, 32'(bus4.write), 32'd0);
    check({name, "_tag"},   32'(bus4.tag),   32'd0);
    check({name, "_busy"},  32'(bus4.busy),  32'd0);
    check({name, "_last"},  32'(bus4.last),  32'd0);
  endtask

  initial begin
    int exp_tags[4];
    exp_t q;

    // Reset asserted with every FIFO non-empty: outputs must stay low.
    bus4.empty = 4'b0000;
    bus4.full  = 1'b0;
    bus1.empty = 4'b1111;
    bus1.full  = 1'b0;
    model_reset();
    #1;
    check_quiet("reset");
    repeat (2) @(negedge clk);
    bus4.empty = 4'b1111;
    rst = 1'b1;

    // Only flux 0 ready: four firings, write on the fourth, then restart.
    for (int c = 0; c < 6; c++) step(4'b1100, 1'b0);

    // Fresh start, both fluxes always ready: grants 0,1,0,1.
    @(negedge clk);
    rst = 1'b0;
    bus4.empty = 4'b1111;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    wtags.delete();
    for (int c = 0; c < 16; c++) step(4'b0000, 1'b0);
    exp_tags = '{0, 1, 0, 1};
    check("grant_count", 32'(wtags.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check("grant_order", (wtags.size() > i) ? 32'(wtags[i]) : 32'hFF, 32'(exp_tags[i]));

    // Flux 1 locked, one of its FIFOs runs dry for 3 cycles while flux 0 is ready.
    for (int c = 0; c < 2; c++) step(4'b0011, 1'b0);
    for (int c = 0; c < 3; c++) step(4'b0100, 1'b0);
    for (int c = 0; c < 2; c++) step(4'b0000, 1'b0);

    // Output full on flux 0's last firing, held for 5 cycles.
    for (int c = 0; c < 3; c++) step(4'b1100, 1'b0);
    for (int c = 0; c < 5; c++) step(4'b1100, 1'b1);
    step(4'b1100, 1'b0);
    step(4'b1111, 1'b0);

    // Reset pulse after two firings of flux 1: outputs drop immediately, no write.
    for (int c = 0; c < 2; c++) step(4'b0011, 1'b0);
    @(negedge clk);
    bus4.empty = 4'b0000;
    rst = 1'b0;
    #1;
    check_quiet("midreset");
    model_reset();
    @(negedge clk);
    #1;
    check_quiet("midreset_hold");
    bus4.empty = 4'b1111;
    rst = 1'b1;
    wtags.delete();
    for (int c = 0; c < 5; c++) step(4'b0000, 1'b0);
    check("post_reset_writes", 32'(wtags.size()), 32'd1);
    check("post_reset_grant", (wtags.size() > 0) ? 32'(wtags[0]) : 32'hFF, 32'd0);
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);

    // NUM_OP=1: every cycle fires and writes, tags alternating.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus1.empty = 4'b0000;
      bus1.full  = 1'b0;
      q.read  = (c % 2 == 0) ? 4'b0011 : 4'b1100;
      q.write = 1'b1;
      q.tag   = 1'(c % 2);
      q.busy  = 1'b0;
      q.last  = 1'b1;
      sb.push_back(q);
      #1;
      q = sb.pop_front();
      check("op1_read",  32'(bus1.read),  32'(q.read));
      check("op1_write", 32'(bus1.write), 32'(q.write));
      check("op1_tag",   32'(bus1.tag),   32'(q.tag));
      check("op1_busy",  32'(bus1.busy),  32'(q.busy));
      check("op1_last",  32'(bus1.last),  32'(q.last));
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
